// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and state type for the Dadda product accumulator
package mac_pkg;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;
  typedef enum logic {ACCUM, HOLD} state_t;
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: W-bit unsigned adder with carry-out, clamping to all-ones on carry when SAT!=0
//   i_a, i_b : addends
//   o_sum    : sum (clamped or wrapped)
//   o_ovf    : carry-out of the raw addition
module mac_sat_add #(
  parameter int W   = 40,
  parameter int SAT = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);
  logic [W:0] w_raw;
  assign w_raw = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf = w_raw[W];
  assign o_sum = (SAT != 0 && o_ovf) ? '1 : w_raw[W-1:0];
endmodule

// File: rtl/dadda_mac_accum.sv
// dadda_mac_accum: accumulates a frame of 32-bit products, one result per frame on valid/ready
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : product beat handshake; in_prod value, in_last ends the frame
//   clr                 : clears running sum/count/overflow (applied before a same-cycle beat)
//   out_valid/out_ready : frame result handshake; out_acc sum, out_cnt terms, out_ovf overflow
module dadda_mac_accum
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);
  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_base, w_acc_sum;
  logic [CNT_W-1:0] r_cnt, w_cnt_base, w_cnt_nxt;
  logic             r_ovf, w_ovf_base, w_ovf_nxt, w_add_ovf, w_accept, w_load;
  assign w_accept   = in_valid && in_ready;
  assign w_load     = w_accept && in_last;
  // clr takes effect before any beat accepted in the same cycle
  assign w_acc_base = clr ? '0 : r_acc;
  assign w_cnt_base = clr ? '0 : r_cnt;
  assign w_ovf_base = clr ? 1'b0 : r_ovf;
  mac_sat_add #(.W(ACC_W), .SAT(SAT)) u_add (
    .i_a  (w_acc_base),
    .i_b  ({{(ACC_W-32){1'b0}}, in_prod}),
    .o_sum(w_acc_sum),
    .o_ovf(w_add_ovf)
  );
  assign w_cnt_nxt = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
  assign w_ovf_nxt = w_ovf_base | w_add_ovf | (&w_cnt_base);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  // a last beat accepted while draining reloads the slot with no bubble
  always_comb
    w_state_nxt = w_load ? HOLD : (out_ready ? ACCUM : r_state);
  always_comb begin
    out_valid = (r_state == HOLD);
    in_ready  = !out_valid || out_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      out_acc <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_load ? '0 : w_acc_sum;
        r_cnt <= w_load ? '0 : w_cnt_nxt;
        r_ovf <= w_load ? 1'b0 : w_ovf_nxt;
      end else if (clr) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
      if (w_load) begin
        out_acc <= w_acc_sum;
        out_cnt <= w_cnt_nxt;
        out_ovf <= w_ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_dadda_mac_accum.sv
// tb_dadda_mac_accum: scoreboard bench driving four parameter variants with shared stimulus
module tb_dadda_mac_accum;
  typedef struct packed {
    logic [63:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_last = 0, clr = 0, out_ready = 0;
  logic [31:0] in_prod = 0;
  logic [63:0] oacc[4];
  logic [7:0]  ocnt[4];
  logic        ovld[4], oovf[4], ird[4];
  logic [39:0] a0, a3;
  logic [32:0] a1, a2;
  logic [7:0]  c0, c1, c2;
  logic [1:0]  c3;
  int          n_cmp = 0, n_err = 0;
  logic [63:0] m_sum = 0;
  int          m_cnt = 0;
  bit          pending = 0, last_stall = 0;
  exp_t        q[4][$];
  logic        stall[4];
  logic [63:0] pacc[4];
  always #5 clk = ~clk;
  dadda_mac_accum #(.ACC_W(40), .CNT_W(8), .SAT(1)) u_d0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ird[0]), .in_prod(in_prod), .in_last(in_last), .clr(clr), .out_valid(ovld[0]),
    .out_ready(out_ready), .out_acc(a0), .out_cnt(c0), .out_ovf(oovf[0]));
  dadda_mac_accum #(.ACC_W(33), .CNT_W(8), .SAT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ird[1]), .in_prod(in_prod), .in_last(in_last), .clr(clr), .out_valid(ovld[1]),
    .out_ready(out_ready), .out_acc(a1), .out_cnt(c1), .out_ovf(oovf[1]));
  dadda_mac_accum #(.ACC_W(33), .CNT_W(8), .SAT(0)) u_d2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ird[2]), .in_prod(in_prod), .in_last(in_last), .clr(clr), .out_valid(ovld[2]),
    .out_ready(out_ready), .out_acc(a2), .out_cnt(c2), .out_ovf(oovf[2]));
  dadda_mac_accum #(.ACC_W(40), .CNT_W(2), .SAT(1)) u_d3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ird[3]), .in_prod(in_prod), .in_last(in_last), .clr(clr), .out_valid(ovld[3]),
    .out_ready(out_ready), .out_acc(a3), .out_cnt(c3), .out_ovf(oovf[3]));
  assign oacc[0] = 64'(a0);
  assign oacc[1] = 64'(a1);
  assign oacc[2] = 64'(a2);
  assign oacc[3] = 64'(a3);
  assign ocnt[0] = c0;
  assign ocnt[1] = c1;
  assign ocnt[2] = c2;
  assign ocnt[3] = 8'(c3);
  function automatic int aw(int i);
    return (i == 1 || i == 2) ? 33 : 40;
  endfunction
  function automatic int cw(int i);
    return (i == 3) ? 2 : 8;
  endfunction
  function automatic bit sat(int i);
    return i != 2;
  endfunction
  // reference: exact frame sum and term count, then clamp or wrap once at the frame end
  function automatic exp_t expect_of(int i, logic [63:0] s, int c);
    exp_t        e;
    logic [63:0] lim;
    int          cmax;
    lim   = 64'd1 << aw(i);
    cmax  = (1 << cw(i)) - 1;
    e.acc = (s >= lim) ? (sat(i) ? lim - 1 : s % lim) : s;
    e.cnt = 8'((c > cmax) ? cmax : c);
    e.ovf = (s >= lim) || (c > cmax);
    return e;
  endfunction
  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask
  task automatic beat(input bit v, input logic [31:0] p, input bit l, input bit c, input bit r);
    bit rdy, acc;
    @(posedge clk);
    #1;
    in_valid = v; in_prod = p; in_last = l; clr = c; out_ready = r;
    @(negedge clk);
    rdy = !pending || r;
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", i, 64'(ovld[i]), 64'(pending));
      chk("in_ready", i, 64'(ird[i]), 64'(rdy));
    end
    acc = v && rdy;
    last_stall = v && !rdy;
    if (c) begin m_sum = 0; m_cnt = 0; end
    if (pending && r) pending = 0;
    if (acc) begin
      m_sum += 64'(p);
      m_cnt++;
      if (l) begin
        for (int i = 0; i < 4; i++) q[i].push_back(expect_of(i, m_sum, m_cnt));
        m_sum = 0; m_cnt = 0; pending = 1;
      end
    end
  endtask
  task automatic check_reset_outputs();
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", i, 64'(ovld[i]), 0);
      chk("rst_acc", i, oacc[i], 0);
      chk("rst_cnt", i, 64'(ocnt[i]), 0);
      chk("rst_ovf", i, 64'(oovf[i]), 0);
      chk("rst_in_ready", i, 64'(ird[i]), 1);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0; in_valid = 0; clr = 0;
    #2;
    check_reset_outputs();
    pending = 0; m_sum = 0; m_cnt = 0; last_stall = 0;
    for (int i = 0; i < 4; i++) q[i].delete();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) stall[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (stall[i]) begin
          chk("hold_valid", i, 64'(ovld[i]), 1);
          chk("hold_acc", i, oacc[i], pacc[i]);
        end
        stall[i] <= ovld[i] && !out_ready;
        pacc[i]  <= oacc[i];
        if (ovld[i] && out_ready) begin
          if (q[i].size() == 0) chk("unexpected_result", i, 1, 0);
          else begin
            exp_t e;
            e = q[i].pop_front();
            chk("out_acc", i, oacc[i], e.acc);
            chk("out_cnt", i, 64'(ocnt[i]), 64'(e.cnt));
            chk("out_ovf", i, 64'(oovf[i]), 64'(e.ovf));
          end
        end
      end
    end
  end
  initial begin
    bit          v, l, c, r;
    logic [31:0] p;
    for (int i = 0; i < 4; i++) stall[i] = 1'b0;
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    beat(1, 6, 0, 0, 1); beat(1, 7, 0, 0, 1); beat(1, 10, 1, 0, 1); beat(0, 0, 0, 0, 1);
    beat(1, 5, 1, 0, 0);
    repeat (5) beat(1, 32'hFFFF_FFFF, 1, 0, 0);
    beat(1, 32'hFFFF_FFFF, 1, 0, 1); beat(0, 0, 0, 0, 1);
    beat(1, 32'hFFFF_FFFF, 0, 0, 1); beat(1, 32'hFFFF_FFFF, 0, 0, 1); beat(1, 2, 1, 0, 1);
    beat(1, 100, 0, 0, 1); beat(1, 9, 0, 1, 1); beat(1, 1, 1, 0, 1);
    repeat (4) beat(1, 1, 0, 0, 1);
    beat(1, 1, 1, 0, 1);
    beat(1, 50, 0, 0, 1); beat(1, 60, 0, 0, 1); beat(0, 0, 0, 1, 1); beat(1, 3, 1, 0, 1);
    beat(1, 50, 0, 0, 1); beat(1, 60, 0, 0, 1);
    do_reset();
    beat(1, 4, 1, 0, 1); beat(0, 0, 0, 0, 1);
    v = 0; p = 0; l = 0;
    for (int k = 0; k < 400; k++) begin
      if (!last_stall) begin
        v = $urandom_range(0, 3) != 0;
        p = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 7)) : $urandom;
        l = $urandom_range(0, 4) == 0;
      end
      c = $urandom_range(0, 15) == 0;
      r = $urandom_range(0, 3) != 0;
      beat(v, p, l, c, r);
    end
    for (int k = 0; k < 10; k++) beat(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) chk("drain_left", i, 64'(q[i].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
